// File: rtl/charge_controller.sv
// charge_controller: coin-operated charging station control FSM with money accumulation, idle timeout and charge countdown.
module charge_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       coin_1,
    input  logic       coin_5,
    input  logic       clear,
    input  logic       confirm,
    output logic [4:0] all_money,
    output logic [5:0] remaining_time,
    output logic       charging,
    output logic       display_en,
    output logic       coin_reject
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] INPUT    = 2'd1;
    localparam logic [1:0] CHARGING = 2'd2;
    localparam logic [3:0] TIMEOUT  = 4'd10;
    logic [1:0] state, state_n;
    logic [3:0] idle_cnt, idle_cnt_n;
    logic [4:0] money_n;
    logic [5:0] time_n;
    logic       reject_n;
    logic [2:0] add;
    logic [5:0] sum;
    logic [5:0] dbl;
    assign add = (coin_5 ? 3'd5 : 3'd0) + {2'b00, coin_1};
    assign sum = {1'b0, all_money} + {3'b000, add};
    assign dbl = {all_money, 1'b0};
    always_comb begin
        state_n    = state;
        idle_cnt_n = idle_cnt;
        money_n    = all_money;
        time_n     = remaining_time;
        reject_n   = 1'b0;
        case (state)
            IDLE: begin
                money_n    = 5'd0;
                time_n     = 6'd0;
                idle_cnt_n = 4'd0;
                state_n    = start ? INPUT : IDLE;
            end
            INPUT: begin
                // confirm outranks clear, clear outranks coins; losers are silently dropped
                if (confirm) begin
                    idle_cnt_n = 4'd0;
                    if (all_money != 5'd0) begin
                        state_n = CHARGING;
                        time_n  = (dbl > 6'd40) ? 6'd40 : dbl;
                    end
                end else if (clear) begin
                    idle_cnt_n = 4'd0;
                    money_n    = 5'd0;
                end else if (coin_1 || coin_5) begin
                    idle_cnt_n = 4'd0;
                    if (sum > 6'd20) reject_n = 1'b1;
                    else money_n = sum[4:0];
                end else if (tick && all_money == 5'd0) begin
                    if (idle_cnt + 4'd1 >= TIMEOUT) begin
                        state_n    = IDLE;
                        idle_cnt_n = 4'd0;
                    end else begin
                        idle_cnt_n = idle_cnt + 4'd1;
                    end
                end
            end
            CHARGING: begin
                if (tick) begin
                    if (remaining_time <= 6'd1) begin
                        state_n = IDLE;
                        time_n  = 6'd0;
                        money_n = 5'd0;
                    end else begin
                        time_n = remaining_time - 6'd1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                money_n    = 5'd0;
                time_n     = 6'd0;
                idle_cnt_n = 4'd0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idle_cnt       <= 4'd0;
            all_money      <= 5'd0;
            remaining_time <= 6'd0;
            charging       <= 1'b0;
            display_en     <= 1'b0;
            coin_reject    <= 1'b0;
        end else begin
            state          <= state_n;
            idle_cnt       <= idle_cnt_n;
            all_money      <= money_n;
            remaining_time <= time_n;
            charging       <= (state_n == CHARGING);
            display_en     <= (state_n != IDLE);
            coin_reject    <= reject_n;
        end
    end
endmodule

// File: doc/charge_controller.md
CHARGE_CONTROLLER -- requirements
Module: charge_controller

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port tick, input, 1, one-cycle enable pulse at 1 Hz from upstream divider; time base for countdown and timeout.
REQ-004 SHALL have port start, input, 1, debounced single-cycle pulse; wakes block from IDLE.
REQ-005 SHALL have port coin_1, input, 1, single-cycle pulse; 1-unit coin inserted.
REQ-006 SHALL have port coin_5, input, 1, single-cycle pulse; 5-unit coin inserted.
REQ-007 SHALL have port clear, input, 1, single-cycle pulse; zero accumulated money in INPUT.
REQ-008 SHALL have port confirm, input, 1, single-cycle pulse; begin charging.
REQ-009 SHALL have port all_money, output, 5, registered accumulated money, binary, 0..20; drives the BCD translator.
REQ-010 SHALL have port remaining_time, output, 6, registered remaining charge ticks, binary, 0..40; drives the BCD translator.
REQ-011 SHALL have port charging, output, 1, registered; high only in CHARGING.
REQ-012 SHALL have port display_en, output, 1, registered; high in INPUT and CHARGING.
REQ-013 SHALL have port coin_reject, output, 1, registered one-cycle pulse; coin(s) refused.

Function
REQ-014 SHALL implement FSM states IDLE, INPUT, CHARGING; encoding free.
REQ-015 SHALL, in IDLE, ignore coin_1, coin_5, clear, confirm, tick; hold all_money=0, remaining_time=0.
REQ-016 SHALL move IDLE->INPUT on start, next cycle; start ignored in INPUT and CHARGING.
REQ-017 SHALL, in INPUT, add coin value(s) to all_money the cycle after the pulse; coin_1 and coin_5 together = add 6.
REQ-018 SHALL, if all_money + added value > 20, leave all_money unchanged and pulse coin_reject for exactly one cycle (both coins refused when simultaneous).
REQ-019 SHALL apply per-cycle priority in INPUT: confirm > clear > coins; lower-priority pulses that cycle are dropped without coin_reject.
REQ-020 SHALL, on clear in INPUT, set all_money=0 and stay in INPUT.
REQ-021 SHALL, on confirm in INPUT with all_money>0, go to CHARGING with remaining_time = 2*all_money (max 40); all_money holds its value; confirm with all_money=0 is ignored.
REQ-022 SHALL keep a 4-bit idle counter in INPUT: cleared on entry, any coin, clear or confirm; increments on tick while all_money=0; on reaching 10 go to IDLE.
REQ-023 SHALL not time out INPUT while all_money>0.
REQ-024 SHALL, in CHARGING, decrement remaining_time by 1 on each tick; coins, clear, confirm ignored (no coin_reject).
REQ-025 SHALL, on tick with remaining_time=1, go to IDLE next cycle with remaining_time=0 and all_money=0.
REQ-026 SHALL never let remaining_time wrap below 0 or all_money exceed 20.
REQ-027 SHALL update charging and display_en in the same cycle as the state register.

Reset
REQ-028 SHALL, while rst high, force state IDLE, all_money=0, remaining_time=0, charging=0, display_en=0, coin_reject=0, idle counter=0, independent of clk.
REQ-029 SHALL abort any mid-operation (INPUT or CHARGING) on rst with no refund memory; first active edge after release evaluates inputs normally.

Verification
REQ-030 SHALL test: start, coin_5, coin_5, coin_1 -> all_money 5,10,11; display_en=1; coin_reject never.
REQ-031 SHALL test: all_money=18, coin_5 -> all_money stays 18, coin_reject one cycle; then coin_1 -> 19; then coin_1+coin_5 same cycle -> stays 19, coin_reject.
REQ-032 SHALL test: all_money=3, confirm -> CHARGING, remaining_time=6, charging=1; 6 ticks -> 5..0, then IDLE, all_money=0, charging=0, display_en=0.
REQ-033 SHALL test: INPUT with all_money=0, 10 ticks no coin -> IDLE; repeat with coin_1 at tick 9 -> stays INPUT.
REQ-034 SHALL test: confirm+clear+coin_1 same cycle at all_money=4 -> CHARGING, remaining_time=8, all_money=4.
REQ-035 SHALL test: rst asserted mid-CHARGING at remaining_time=17 between clock edges -> all outputs 0 immediately, state IDLE.
